// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and widths for the memory arbiter
package mem_arbiter_pkg;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 64;
    localparam int BE_W        = 8;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IF_BUSY,
        ST_LSU_BUSY,
        ST_RESP
    } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM bus bundle for the memory arbiter
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_inst;

    logic              lsu_req;
    logic              lsu_wen;
    logic [ADDR_W-1:0] lsu_addr;
    logic [BE_W-1:0]   lsu_be;
    logic [DATA_W-1:0] lsu_wdata;
    logic              lsu_ack;
    logic [DATA_W-1:0] lsu_rdata;

    logic              err;
    logic              stop_all;

    logic              ram_req;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wen;
    logic [BE_W-1:0]   ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;

    // arbiter side
    modport slave (
        input  if_req, if_addr, lsu_req, lsu_wen, lsu_addr, lsu_be, lsu_wdata,
        input  ram_rdata, ram_ack,
        output if_ack, if_inst, lsu_ack, lsu_rdata, err, stop_all,
        output ram_req, ram_addr, ram_wen, ram_be, ram_wdata
    );

    // requester / RAM side
    modport master (
        output if_req, if_addr, lsu_req, lsu_wen, lsu_addr, lsu_be, lsu_wdata,
        output ram_rdata, ram_ack,
        input  if_ack, if_inst, lsu_ack, lsu_rdata, err, stop_all,
        input  ram_req, ram_addr, ram_wen, ram_be, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority LSU/IF arbiter onto one 64-bit RAM port with timeout
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_addr2;
    logic [DATA_W-1:0] r_rdata;
    logic              r_if_ack;
    logic              r_lsu_ack;
    logic              r_err;
    logic              r_ram_req;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_wen;
    logic [BE_W-1:0]   r_ram_be;
    logic [DATA_W-1:0] r_ram_wdata;

    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_unused;

    assign w_cnt_next = r_cnt + CNT_W'(1);
    // RAM is 64-bit word addressed; sub-word address bits never reach it
    assign w_unused   = &{1'b0, bus.if_addr[1:0], bus.lsu_addr[2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr2     <= 1'b0;
            r_rdata     <= '0;
            r_if_ack    <= 1'b0;
            r_lsu_ack   <= 1'b0;
            r_err       <= 1'b0;
            r_ram_req   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wen   <= 1'b0;
            r_ram_be    <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_if_ack  <= 1'b0;
            r_lsu_ack <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.lsu_req) begin
                        r_ram_req   <= 1'b1;
                        r_ram_addr  <= {bus.lsu_addr[ADDR_W-1:3], 3'b000};
                        r_ram_wen   <= bus.lsu_wen;
                        r_ram_be    <= bus.lsu_be;
                        r_ram_wdata <= bus.lsu_wdata;
                        r_cnt       <= '0;
                        r_state     <= ST_LSU_BUSY;
                    end else if (bus.if_req) begin
                        r_ram_req   <= 1'b1;
                        r_ram_addr  <= {bus.if_addr[ADDR_W-1:3], 3'b000};
                        r_ram_wen   <= 1'b0;
                        r_ram_be    <= '1;
                        r_ram_wdata <= '0;
                        r_addr2     <= bus.if_addr[2];
                        r_cnt       <= '0;
                        r_state     <= ST_IF_BUSY;
                    end
                end
                ST_IF_BUSY, ST_LSU_BUSY: begin
                    // a real ack in the last allowed cycle wins over the timeout
                    if (bus.ram_ack) begin
                        r_rdata   <= bus.ram_rdata;
                        r_ram_req <= 1'b0;
                        r_if_ack  <= (r_state == ST_IF_BUSY);
                        r_lsu_ack <= (r_state == ST_LSU_BUSY);
                        r_state   <= ST_RESP;
                    end else if (w_cnt_next == CNT_W'(TIMEOUT)) begin
                        r_rdata   <= '0;
                        r_ram_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_if_ack  <= (r_state == ST_IF_BUSY);
                        r_lsu_ack <= (r_state == ST_LSU_BUSY);
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_ack    = r_if_ack;
    assign bus.if_inst   = r_addr2 ? r_rdata[63:32] : r_rdata[31:0];
    assign bus.lsu_ack   = r_lsu_ack;
    assign bus.lsu_rdata = r_rdata;
    assign bus.err       = r_err;
    assign bus.stop_all  = (bus.if_req & ~r_if_ack) | (bus.lsu_req & ~r_lsu_ack);
    assign bus.ram_req   = r_ram_req;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wen   = r_ram_wen;
    assign bus.ram_be    = r_ram_be;
    assign bus.ram_wdata = r_ram_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [63:0] last_rd = '0;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start at the negedge of an IDLE cycle with the request already driven.
    // d = BUSY cycle (1-based) carrying ram_ack; d > T means the RAM never answers.
    task automatic do_access(input bit is_lsu, input int d, input logic [63:0] rd, input bit early_drop);
        logic [31:0] a;
        logic [7:0]  be;
        logic [63:0] wd;
        logic        we;
        logic [63:0] exp_rd;
        logic        exp_ia;
        logic        exp_la;
        bit          to;
        int          e;
        a      = is_lsu ? bus.lsu_addr : bus.if_addr;
        be     = is_lsu ? bus.lsu_be : 8'hFF;
        wd     = bus.lsu_wdata;
        we     = is_lsu ? bus.lsu_wen : 1'b0;
        to     = (d > T);
        e      = to ? T + 1 : d + 1;
        exp_rd = to ? 64'd0 : rd;
        @(posedge clk);
        for (int c = 1; c <= e + 1; c++) begin
            @(negedge clk);
            bus.ram_ack   = 1'b0;
            bus.ram_rdata = {$urandom, $urandom};
            exp_ia = (c == e) && !is_lsu;
            exp_la = (c == e) && is_lsu;
            chk("stop_all", bus.stop_all, (bus.if_req & ~exp_ia) | (bus.lsu_req & ~exp_la));
            if (c == 1) begin
                if (is_lsu) begin
                    bus.lsu_addr  = $urandom;
                    bus.lsu_be    = 8'($urandom);
                    bus.lsu_wen   = 1'($urandom);
                    bus.lsu_wdata = {$urandom, $urandom};
                end else begin
                    bus.if_addr = $urandom;
                end
            end
            if (c < e) begin
                chk("busy_ram_req", bus.ram_req, 1'b1);
                chk("busy_ram_addr", bus.ram_addr, {a[31:3], 3'b000});
                chk("busy_ram_wen", bus.ram_wen, we);
                chk("busy_ram_be", bus.ram_be, be);
                if (is_lsu) chk("busy_ram_wdata", bus.ram_wdata, wd);
                chk("busy_no_ack", {bus.if_ack, bus.lsu_ack, bus.err}, 3'b000);
                if (c == d) begin
                    bus.ram_ack   = 1'b1;
                    bus.ram_rdata = rd;
                end
                if (early_drop && c == 1) begin
                    if (is_lsu) bus.lsu_req = 1'b0;
                    else        bus.if_req  = 1'b0;
                end
            end else if (c == e) begin
                chk("resp_if_ack", bus.if_ack, !is_lsu);
                chk("resp_lsu_ack", bus.lsu_ack, is_lsu);
                chk("resp_err", bus.err, to);
                chk("resp_ram_req", bus.ram_req, 1'b0);
                if (is_lsu) chk("resp_lsu_rdata", bus.lsu_rdata, exp_rd);
                else        chk("resp_if_inst", bus.if_inst, a[2] ? exp_rd[63:32] : exp_rd[31:0]);
                last_rd = exp_rd;
                if (is_lsu) bus.lsu_req = 1'b0;
                else        bus.if_req  = 1'b0;
                // a stray ack while in RESP must be ignored
                bus.ram_ack = 1'($urandom);
            end else begin
                chk("idle_acks", {bus.if_ack, bus.lsu_ack, bus.err}, 3'b000);
                chk("idle_ram_req", bus.ram_req, 1'b0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, d1, d2;
        bit ed;
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = 0;
        bus.lsu_req = 0; bus.lsu_wen = 0; bus.lsu_addr = 0; bus.lsu_be = 0; bus.lsu_wdata = 0;
        bus.ram_ack = 0; bus.ram_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_req", bus.ram_req, 1'b0);
        chk("rst_acks", {bus.if_ack, bus.lsu_ack, bus.err}, 3'b000);
        chk("rst_if_inst", bus.if_inst, 32'd0);
        chk("rst_lsu_rdata", bus.lsu_rdata, 64'd0);
        chk("rst_ram_addr", bus.ram_addr, 32'd0);
        chk("rst_ram_wen_be", {bus.ram_wen, bus.ram_be}, 9'd0);
        chk("rst_ram_wdata", bus.ram_wdata, 64'd0);
        chk("rst_stop_all", bus.stop_all, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // single IF read, upper word
        bus.if_req = 1; bus.if_addr = 32'h8000_0004;
        do_access(0, 1, 64'h1111_2222_3333_4444, 0);

        // simultaneous: LSU store first, IF right after
        bus.if_req = 1; bus.if_addr = 32'h8000_0010;
        bus.lsu_req = 1; bus.lsu_wen = 1; bus.lsu_be = 8'h0F;
        bus.lsu_addr = 32'h8000_1003; bus.lsu_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        do_access(1, 2, 64'h0, 0);
        do_access(0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 0);

        // timeout on LSU load
        bus.lsu_req = 1; bus.lsu_wen = 0; bus.lsu_be = 8'hFF; bus.lsu_addr = 32'h0000_0100;
        do_access(1, 100, 64'h0, 0);

        // ack in the last allowed BUSY cycle; stop_all held across the wait
        bus.if_req = 1; bus.if_addr = 32'h0000_2000;
        do_access(0, T, 64'h0123_4567_89AB_CDEF, 0);

        // stray ack in IDLE
        bus.ram_ack = 1; bus.ram_rdata = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        bus.ram_ack = 0;
        chk("stray_acks", {bus.if_ack, bus.lsu_ack, bus.err}, 3'b000);
        chk("stray_ram_req", bus.ram_req, 1'b0);
        chk("stray_lsu_rdata", bus.lsu_rdata, last_rd);

        // reset mid-access, then a late ram_ack
        bus.lsu_req = 1; bus.lsu_wen = 0; bus.lsu_addr = 32'h0000_0040; bus.lsu_be = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        chk("rma_ram_req_busy", bus.ram_req, 1'b1);
        rst = 1;
        @(negedge clk);
        rst = 0; bus.lsu_req = 0;
        chk("rma_ram_req_drop", bus.ram_req, 1'b0);
        bus.ram_ack = 1; bus.ram_rdata = 64'h5555_5555_5555_5555;
        @(negedge clk);
        bus.ram_ack = 0;
        chk("rma_no_ack", {bus.if_ack, bus.lsu_ack, bus.err}, 3'b000);
        chk("rma_ram_req", bus.ram_req, 1'b0);
        chk("rma_lsu_rdata", bus.lsu_rdata, 64'd0);
        bus.lsu_req = 1; bus.lsu_wen = 0; bus.lsu_addr = 32'h0000_0048; bus.lsu_be = 8'hF0;
        do_access(1, 1, 64'h9876_5432_1000_0001, 0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            d1 = $urandom_range(1, T + 2);
            d2 = $urandom_range(1, T + 2);
            ed = (kind != 2) && ($urandom_range(0, 7) == 0);
            if (kind != 1) begin
                bus.if_req = 1; bus.if_addr = $urandom;
            end
            if (kind != 0) begin
                bus.lsu_req = 1; bus.lsu_wen = 1'($urandom); bus.lsu_addr = $urandom;
                bus.lsu_be = 8'($urandom); bus.lsu_wdata = {$urandom, $urandom};
            end
            if (kind == 0) do_access(0, d1, {$urandom, $urandom}, ed);
            else           do_access(1, d1, {$urandom, $urandom}, ed);
            if (kind == 2) do_access(0, d2, {$urandom, $urandom}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles to wait for ram_ack before aborting an access.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req  input  1  fetch request; held high by requester until if_ack.
REQ-005 if_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 if_ack  output  1  one-cycle pulse; if_inst valid.
REQ-007 if_inst  output  32  fetched instruction word.
REQ-008 lsu_req  input  1  data request; held high until lsu_ack.
REQ-009 lsu_wen  input  1  1 = store, 0 = load.
REQ-010 lsu_addr  input  32  data byte address.
REQ-011 lsu_be  input  8  byte enables, 1 = byte active.
REQ-012 lsu_wdata  input  64  store data, lane-aligned.
REQ-013 lsu_ack  output  1  one-cycle pulse; lsu_rdata valid for loads.
REQ-014 lsu_rdata  output  64  raw 64-bit load data.
REQ-015 err  output  1  one-cycle pulse with the ack of a timed-out access.
REQ-016 stop_all  output  1  pipeline stall; high while any request is pending and not yet acked.
REQ-017 ram_req  output  1  external RAM request, held until ram_ack.
REQ-018 ram_addr  output  32  RAM address; bits [2:0] always 0.
REQ-019 ram_wen  output  1  RAM write enable.
REQ-020 ram_be  output  8  RAM byte enables.
REQ-021 ram_wdata  output  64  RAM write data.
REQ-022 ram_rdata  input  64  RAM read data, valid with ram_ack.
REQ-023 ram_ack  input  1  RAM completion, one-cycle.

Function
REQ-024 FSM states: IDLE, IF_BUSY, LSU_BUSY, RESP.
REQ-025 In IDLE with lsu_req=1, the block shall latch the LSU fields and go to LSU_BUSY; else with if_req=1, it shall latch if_addr and go to IF_BUSY. LSU has fixed priority.
REQ-026 Fields are latched at grant; requester changes after grant shall not affect the access.
REQ-027 ram_req shall be 1 exactly in IF_BUSY and LSU_BUSY, driven from latched registers.
REQ-028 IF access: ram_wen=0, ram_be=8'hFF, ram_addr={if_addr[31:3],3'b0}.
REQ-029 LSU access: ram_wen=lsu_wen, ram_be=lsu_be, ram_wdata=lsu_wdata, ram_addr={lsu_addr[31:3],3'b0}.
REQ-030 On ram_ack in a BUSY state, ram_rdata shall be registered and the state shall go to RESP.
REQ-031 In RESP, the matching ack shall pulse for exactly one cycle, then the state returns to IDLE. Minimum grant-to-ack latency is 2 cycles when ram_ack arrives in the first BUSY cycle.
REQ-032 if_inst = latched if_addr[2] ? rdata[63:32] : rdata[31:0]; lsu_rdata = rdata.
REQ-033 A wait counter shall clear on entry to BUSY and increment each BUSY cycle without ram_ack.
REQ-034 When the counter reaches TIMEOUT, the block shall go to RESP with rdata=0 and err=1 alongside the ack.
REQ-035 ram_ack outside BUSY states shall be ignored.
REQ-036 stop_all = (if_req & ~if_ack) | (lsu_req & ~lsu_ack), combinational.
REQ-037 A request deasserted before its ack is a protocol violation; the access still completes and the ack still pulses.
REQ-038 On simultaneous requests, LSU is served first and IF is served in the IDLE cycle that follows.

Reset
REQ-039 rst shall force IDLE, counter=0, and all data registers=0.
REQ-040 Reset values: ram_req, if_ack, lsu_ack, err = 0; if_inst, lsu_rdata = 0; ram_* outputs = 0.
REQ-041 Reset mid-access shall drop ram_req at the next edge with no ack issued; a later ram_ack shall be ignored.

Structure
REQ-042 A shared package shall hold the FSM state enum, the default TIMEOUT, and the RAM width constants (ADDR_W=32, DATA_W=64, BE_W=8).
REQ-043 The design shall be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-044 Single IF read: if_req, if_addr=0x80000004, ram_ack on the first BUSY cycle with rdata=0x11112222_33334444 -> if_ack 2 cycles after grant, if_inst=0x11112222.
REQ-045 Simultaneous requests: if_req and lsu_req (store, be=0x0F, addr 0x80001003) in the same cycle -> LSU is served first with ram_addr=0x80001000, ram_wen=1; IF is granted after lsu_ack.
REQ-046 Timeout: LSU load with ram_ack never asserted, TIMEOUT=4 -> lsu_ack and err pulse together, lsu_rdata=0, ram_req drops.
REQ-047 Reset mid-access: rst during LSU_BUSY, then ram_ack one cycle later -> no ack, ram_req=0, next request is served normally.
REQ-048 stop_all: if_req held for 5 cycles until if_ack -> stop_all=1 on every one of those cycles, and 0 in the cycle after if_req deasserts.
REQ-049 Stray ram_ack in IDLE -> no output change.
